temporal_ngram_encoder: RTL and testbench
=========================================

Name: temporal_ngram_encoder

Overview:
Upstream neighbour of the associative memory. Accepts one spatially encoded hypervector per sample and binds the last NGRAM_SIZE samples into one temporal N-gram hypervector by cyclic permutation and XOR. The N-gram drives the AM query input with the same valid/ready handshake the AM uses. Sliding window: once the window is full, every accepted sample produces one N-gram.

Parameters:
HV_DIMENSION, `HV_DIMENSION (const.vh), hypervector width in bits; must be >= 2.
NGRAM_SIZE, 3, samples bound per N-gram; legal range 1..8.
FILL_WIDTH, 3, width of the fill counter; must hold NGRAM_SIZE-1.

Ports:
Clk_CI  in  1  clock; all state updates on the rising edge.
Reset_RBI  in  1  reset, asynchronous, active-low; clears all state immediately.
ValidIn_SI  in  1  upstream sample valid.
ReadyOut_SO  out  1  encoder can accept a sample.
HypervectorIn_DI  in  [0:HV_DIMENSION-1]  spatial hypervector.
ValidOut_SO  out  1  N-gram valid toward the AM.
ReadyIn_SI  in  1  AM ready, i.e. AM in IDLE.
HypervectorOut_DO  out  [0:HV_DIMENSION-1]  registered N-gram.

Behaviour:
- Permutation rho(x): rotate by one position toward higher index.
  - rho(x)[i+1] = x[i]; rho(x)[0] = x[HV_DIMENSION-1].
  - Example, DIM=8: 1000_0000 -> 0100_0000.
- History: NGRAM_SIZE-1 registers P[1..NGRAM_SIZE-1], stored pre-permuted.
  - P[1] = rho(H[t-1]).
  - P[k] = rho(P[k-1] of the previous sample).
- N-gram: NG = HypervectorIn_DI ^ P[1] ^ ... ^ P[NGRAM_SIZE-1], computed combinationally from pre-update history.
  - NGRAM_SIZE=1: NG = HypervectorIn_DI.
- On each accept (ValidIn_SI & ReadyOut_SO):
  - P[1] <= rho(In).
  - P[k] <= rho(P[k-1]).
  - FillCnt_SP increments, saturating at NGRAM_SIZE-1.
- FSM states: ACCEPT (2'd0), OUTPUT_STABLE (2'd1).
  - ACCEPT: ReadyOut_SO=1, ValidOut_SO=0.
    - Accept with FillCnt_SP < NGRAM_SIZE-1: update history, stay in ACCEPT, no output.
    - Accept with FillCnt_SP == NGRAM_SIZE-1: update history, load output register with NG, go to OUTPUT_STABLE.
    - No accept: stay in ACCEPT.
  - OUTPUT_STABLE: ReadyOut_SO=0, ValidOut_SO=1.
    - Output register and history are frozen.
    - ReadyIn_SI=1: handshake completes this cycle, next state ACCEPT.
    - ReadyIn_SI=0: stay in OUTPUT_STABLE.
- Latency: the N-gram is valid one cycle after the window-completing accept.
- Throughput: at most one N-gram per 2 cycles; the AM is slower, so this is not limiting.
- ReadyOut_SO and ValidOut_SO are decoded from state only. Neither depends combinationally on ValidIn_SI or ReadyIn_SI.
- Reset values: state ACCEPT, FillCnt_SP=0, all P[k]=0, HypervectorOut_DO=0, ValidOut_SO=0.
  - ReadyOut_SO=1 while in reset and after reset.
- Reset mid-operation, in any state: all state clears asynchronously. Any pending N-gram is dropped and the window restarts empty.
- ValidIn_SI during OUTPUT_STABLE: ignored. The sample is not consumed; upstream holds it.
- ValidOut_SO and HypervectorOut_DO stay stable until the handshake completes.
- The sliding window continues across N-grams; the fill count does not reset after an output.

Optional Feature:
TEMPORAL_FLUSH_EN:
- When defined, adds input port FlushIn_SI (1 bit).
- FlushIn_SI=1 in ACCEPT on a cycle without an accept: FillCnt_SP <= 0 and all P[k] <= 0; no output.
- FlushIn_SI=1 in ACCEPT together with an accept: flush takes priority over the accept.
  - The sample is treated as the first sample of a new window.
  - FillCnt_SP <= 1 (0 when NGRAM_SIZE=1), P[1] <= rho(In), and all other P[k] <= 0.
  - NGRAM_SIZE=1 only: the flushed sample completes the window. The output register loads NG = In and the FSM goes to OUTPUT_STABLE.
  - NGRAM_SIZE>1: no N-gram is produced from that accept.
- FlushIn_SI in OUTPUT_STABLE: ignored.
- When not defined: no port; the window is cleared only by reset.

Test Plan:
- DIM=8, N=3, reset, then accept 8'h80, 8'h80, 8'h80 -> no ValidOut_SO after the first two; 8'hE0 valid one cycle after the third.
- Continue: accept 8'h01 with ReadyIn_SI=1 -> sliding N-gram 8'h61 (01^40^20); ReadyOut_SO low exactly one cycle.
- Hold ReadyIn_SI=0 for 5 cycles in OUTPUT_STABLE while ValidIn_SI=1 with 8'hFF -> output stays 8'hE0, ReadyOut_SO=0, sample not consumed; release ReadyIn_SI -> 8'hFF accepted next.
- Rotation wrap: accept 8'h01, 8'h00, 8'h00 -> output 8'h40 (bit7 rotated to bit0, then bit1).
- Assert Reset_RBI low mid-window after two samples, then release and send three samples of 8'h80 -> first output 8'hE0, with no contribution from earlier history.
- TEMPORAL_FLUSH_EN defined: sample 8'h80, FlushIn_SI pulse, then 8'h80, 8'h80, 8'h80 -> output 8'hE0; with the macro undefined the port is absent.

Source files
------------

// File: rtl/temporal_ngram_encoder_if.sv
// -----------------------------------------------------------------------------
// temporal_ngram_encoder_if
// Carries the handshake and data signals of the temporal N-gram encoder.
//   Upstream side : ValidIn_SI / ReadyOut_SO / HypervectorIn_DI
//   AM side       : ValidOut_SO / ReadyIn_SI / HypervectorOut_DO
//   FlushIn_SI    : exists only when TEMPORAL_FLUSH_EN is defined
// Modports:
//   master : the environment (sample source + associative memory)
//   slave  : the encoder itself
// -----------------------------------------------------------------------------
interface temporal_ngram_encoder_if #(
  parameter int HV_DIMENSION = 8
);
  logic                    ValidIn_SI;
  logic                    ReadyOut_SO;
  logic [0:HV_DIMENSION-1] HypervectorIn_DI;
  logic                    ValidOut_SO;
  logic                    ReadyIn_SI;
  logic [0:HV_DIMENSION-1] HypervectorOut_DO;
`ifdef TEMPORAL_FLUSH_EN
  logic                    FlushIn_SI;

  modport master (
    output ValidIn_SI, HypervectorIn_DI, ReadyIn_SI, FlushIn_SI,
    input  ReadyOut_SO, ValidOut_SO, HypervectorOut_DO
  );

  modport slave (
    input  ValidIn_SI, HypervectorIn_DI, ReadyIn_SI, FlushIn_SI,
    output ReadyOut_SO, ValidOut_SO, HypervectorOut_DO
  );
`else
  modport master (
    output ValidIn_SI, HypervectorIn_DI, ReadyIn_SI,
    input  ReadyOut_SO, ValidOut_SO, HypervectorOut_DO
  );

  modport slave (
    input  ValidIn_SI, HypervectorIn_DI, ReadyIn_SI,
    output ReadyOut_SO, ValidOut_SO, HypervectorOut_DO
  );
`endif
endinterface

// File: rtl/temporal_ngram_encoder.sv
// -----------------------------------------------------------------------------
// temporal_ngram_encoder
// Binds the last NGRAM_SIZE spatial hypervectors into one temporal N-gram
// (cyclic permutation + XOR) and hands it to the associative memory.
// Sliding window: once full, every accepted sample yields one N-gram.
//
// Ports:
//   Clk_CI    : clock, rising edge
//   Reset_RBI : asynchronous active-low reset
//   bus       : temporal_ngram_encoder_if.slave (sample in, N-gram out)
//
// Optional feature macro: TEMPORAL_FLUSH_EN (adds bus.FlushIn_SI, which
// empties the window from the ACCEPT state).
//
// State table:
//   ST_ACCEPT        | ready for a sample, no N-gram pending
//   ST_OUTPUT_STABLE | N-gram held on the output until the AM takes it
// -----------------------------------------------------------------------------
module temporal_ngram_encoder #(
  parameter int HV_DIMENSION = 8,
  parameter int NGRAM_SIZE   = 3,
  parameter int FILL_WIDTH   = 3
) (
  input logic                      Clk_CI,
  input logic                      Reset_RBI,
  temporal_ngram_encoder_if.slave  bus
);

  localparam logic [1:0] ST_ACCEPT        = 2'd0;
  localparam logic [1:0] ST_OUTPUT_STABLE = 2'd1;

  // At least one history slot is kept so the array is legal for NGRAM_SIZE=1;
  // in that case the slot never contributes to the N-gram.
  localparam int HIST = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;

  localparam logic [FILL_WIDTH-1:0] FILL_MAX   = FILL_WIDTH'(NGRAM_SIZE - 1);
  localparam logic [FILL_WIDTH-1:0] FILL_FIRST = (NGRAM_SIZE > 1) ? FILL_WIDTH'(1) : '0;

  logic [1:0]              r_state;
  logic [FILL_WIDTH-1:0]   r_fill;
  logic [0:HV_DIMENSION-1] r_hist [0:HIST-1];
  logic [0:HV_DIMENSION-1] r_out;

  logic                    w_accept;
  logic                    w_full;
  logic                    w_flush;
  logic [0:HV_DIMENSION-1] w_ngram;

  // Rotate one position toward higher index; the last bit wraps to index 0.
  function automatic logic [0:HV_DIMENSION-1] rho(input logic [0:HV_DIMENSION-1] x);
    return {x[HV_DIMENSION-1], x[0:HV_DIMENSION-2]};
  endfunction

  assign w_accept = bus.ValidIn_SI & (r_state == ST_ACCEPT);
  assign w_full   = (r_fill == FILL_MAX);

`ifdef TEMPORAL_FLUSH_EN
  assign w_flush = bus.FlushIn_SI & (r_state == ST_ACCEPT);
`else
  assign w_flush = 1'b0;
`endif

  // History is stored already permuted, so the N-gram is a plain XOR.
  always_comb begin
    w_ngram = bus.HypervectorIn_DI;
    for (int k = 0; k < NGRAM_SIZE - 1; k++) begin
      w_ngram = w_ngram ^ r_hist[k];
    end
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      r_state <= ST_ACCEPT;
      r_fill  <= '0;
      r_out   <= '0;
      for (int k = 0; k < HIST; k++) begin
        r_hist[k] <= '0;
      end
    end else begin
      case (r_state)
        ST_ACCEPT: begin
          if (w_flush) begin
            // The flushed sample (if any) opens a fresh window.
            for (int k = 0; k < HIST; k++) begin
              r_hist[k] <= '0;
            end
            if (w_accept) begin
              r_hist[0] <= rho(bus.HypervectorIn_DI);
              r_fill    <= FILL_FIRST;
              if (NGRAM_SIZE == 1) begin
                r_out   <= bus.HypervectorIn_DI;
                r_state <= ST_OUTPUT_STABLE;
              end
            end else begin
              r_fill <= '0;
            end
          end else if (w_accept) begin
            r_hist[0] <= rho(bus.HypervectorIn_DI);
            for (int k = 1; k < HIST; k++) begin
              r_hist[k] <= rho(r_hist[k-1]);
            end
            if (w_full) begin
              r_out   <= w_ngram;
              r_state <= ST_OUTPUT_STABLE;
            end else begin
              r_fill <= r_fill + FILL_WIDTH'(1);
            end
          end
        end
        ST_OUTPUT_STABLE: begin
          if (bus.ReadyIn_SI) begin
            r_state <= ST_ACCEPT;
          end
        end
        default: r_state <= ST_ACCEPT;
      endcase
    end
  end

  assign bus.ReadyOut_SO       = (r_state == ST_ACCEPT);
  assign bus.ValidOut_SO       = (r_state == ST_OUTPUT_STABLE);
  assign bus.HypervectorOut_DO = r_out;

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
module tb_temporal_ngram_encoder;
  localparam int D = 8;
  localparam int N = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  temporal_ngram_encoder_if #(.HV_DIMENSION(D)) u_if ();

  temporal_ngram_encoder #(
    .HV_DIMENSION(D),
    .NGRAM_SIZE  (N),
    .FILL_WIDTH  (3)
  ) dut (
    .Clk_CI   (clk),
    .Reset_RBI(rst_n),
    .bus      (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: window of raw samples (most recent first), since reset/flush.
  logic [0:D-1] hist_q[$];
  int           m_cnt;
  bit           m_pend;
  logic [0:D-1] m_out;

  // Rotate by k positions toward higher index.
  function automatic logic [0:D-1] rotk(input logic [0:D-1] x, input int k);
    logic [0:D-1] y;
    for (int i = 0; i < D; i++) y[(i + k) % D] = x[i];
    return y;
  endfunction

  task automatic model_clear();
    hist_q.delete();
    m_cnt  = 0;
    m_pend = 0;
    m_out  = '0;
  endtask

  // One clock cycle: drive inputs, advance the model, check outputs after the edge.
  task automatic cycle(input bit vin, input logic [0:D-1] d, input bit rin, input bit fl);
    logic [0:D-1] ng;
    u_if.ValidIn_SI       = vin;
    u_if.HypervectorIn_DI = d;
    u_if.ReadyIn_SI       = rin;
`ifdef TEMPORAL_FLUSH_EN
    u_if.FlushIn_SI       = fl;
`endif
    if (!m_pend) begin
`ifdef TEMPORAL_FLUSH_EN
      if (fl) begin
        hist_q.delete();
        m_cnt = 0;
      end
`endif
      if (vin) begin
        ng = d;
        for (int k = 1; k < N; k++)
          if (k <= hist_q.size()) ng = ng ^ rotk(hist_q[k-1], k);
        hist_q.push_front(d);
        if (hist_q.size() > N) void'(hist_q.pop_back());
        m_cnt++;
        if (m_cnt >= N) begin
          m_out  = ng;
          m_pend = 1;
        end
      end
    end else if (rin) begin
      m_pend = 0;
    end
    @(posedge clk);
    #1;
    checks++;
    if (u_if.ReadyOut_SO !== !m_pend) begin
      errors++;
      $display("FAIL ready: got %b expected %b at %0t", u_if.ReadyOut_SO, !m_pend, $time);
    end
    checks++;
    if (u_if.ValidOut_SO !== m_pend) begin
      errors++;
      $display("FAIL valid: got %b expected %b at %0t", u_if.ValidOut_SO, m_pend, $time);
    end
    checks++;
    if (u_if.HypervectorOut_DO !== m_out) begin
      errors++;
      $display("FAIL ngram: got %h expected %h at %0t", u_if.HypervectorOut_DO, m_out, $time);
    end
  endtask

  task automatic expect_out(input string name, input logic [0:D-1] exp_v);
    checks++;
    if (u_if.ValidOut_SO !== 1'b1 || u_if.HypervectorOut_DO !== exp_v) begin
      errors++;
      $display("FAIL %s: got valid=%b data=%h expected valid=1 data=%h",
               name, u_if.ValidOut_SO, u_if.HypervectorOut_DO, exp_v);
    end
  endtask

  task automatic do_reset();
    u_if.ValidIn_SI       = 1'b0;
    u_if.HypervectorIn_DI = '0;
    u_if.ReadyIn_SI       = 1'b0;
`ifdef TEMPORAL_FLUSH_EN
    u_if.FlushIn_SI       = 1'b0;
`endif
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if (u_if.ReadyOut_SO !== 1'b1 || u_if.ValidOut_SO !== 1'b0 || u_if.HypervectorOut_DO !== '0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b valid=%b data=%h expected ready=1 valid=0 data=00",
               u_if.ReadyOut_SO, u_if.ValidOut_SO, u_if.HypervectorOut_DO);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    cycle(0, '0, 0, 0);
  endtask

  task automatic test_fill_and_hold();
    do_reset();
    cycle(1, 8'h80, 0, 0);
    cycle(1, 8'h80, 0, 0);
    cycle(1, 8'h80, 0, 0);
    expect_out("fill_e0", 8'hE0);
    for (int i = 0; i < 5; i++) cycle(1, 8'hFF, 0, 0);
    expect_out("hold_e0", 8'hE0);
    cycle(1, 8'hFF, 1, 0);
    cycle(1, 8'hFF, 1, 0);
    expect_out("held_sample_9f", 8'h9F);
    cycle(0, '0, 1, 0);
  endtask

  task automatic test_sliding();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 8'h80, 1, 0);
    expect_out("slide_first_e0", 8'hE0);
    cycle(1, 8'h01, 1, 0);
    cycle(1, 8'h01, 1, 0);
    expect_out("slide_61", 8'h61);
    cycle(0, '0, 1, 0);
  endtask

  task automatic test_rotation_wrap();
    do_reset();
    cycle(1, 8'h01, 1, 0);
    cycle(1, 8'h00, 1, 0);
    cycle(1, 8'h00, 1, 0);
    expect_out("wrap_40", 8'h40);
    cycle(0, '0, 1, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1, 8'hAA, 1, 0);
    cycle(1, 8'h55, 1, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 8'h80, 1, 0);
    expect_out("after_reset_e0", 8'hE0);
    cycle(0, '0, 1, 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 24; i++) cycle(1, D'($urandom), 1, 0);
  endtask

`ifdef TEMPORAL_FLUSH_EN
  task automatic test_flush();
    do_reset();
    cycle(1, 8'h80, 1, 0);
    cycle(0, 8'h00, 1, 1);
    cycle(1, 8'h80, 1, 0);
    cycle(1, 8'h80, 1, 0);
    cycle(1, 8'h80, 1, 0);
    expect_out("flush_e0", 8'hE0);
    cycle(0, '0, 1, 0);
    cycle(1, 8'h3C, 1, 0);
    cycle(1, 8'h11, 1, 1);
    for (int i = 0; i < 4; i++) cycle(1, D'($urandom), 1, 0);
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), D'($urandom), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_clear();
    test_reset();
    test_fill_and_hold();
    test_sliding();
    test_rotation_wrap();
    test_reset_mid();
    test_back_to_back();
`ifdef TEMPORAL_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
